// File: rtl/softmax_norm_ctrl.sv
// Normalisation sequencer for softmax exponential sums: a leading-one detector drives a
// fixed-latency IDLE/DETECT/NORM/OUT FSM producing (mantissa, signed exponent) with back-pressure.
module softmax_norm_ctrl #(
   parameter int Q_FRAC = 16,
   parameter int MANT_W = 16,
   parameter int EXP_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_num,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mant,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_zero,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DETECT = 2'd1,
      ST_NORM   = 2'd2,
      ST_OUT    = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] num_r;
   logic [4:0]  pos_r;
   logic        zero_r;

   logic [31:0]       shift_s;
   logic [MANT_W-1:0] mant_s;
   logic [EXP_W-1:0]  exp_s;

   // Highest set bit index; returns 0 for a zero word (callers track zero separately).
   function automatic logic [4:0] lod(input logic [31:0] v);
      logic [4:0] p;
      p = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            p = 5'(i);
         end
      end
      return p;
   endfunction

   // Left-justify the leading one and derive the unbiased exponent.
   always_comb begin
      shift_s = num_r << (5'd31 - pos_r);
      mant_s  = shift_s[31 -: MANT_W];
      // Zero-extend then subtract modulo 2^EXP_W yields the two's-complement result.
      exp_s   = EXP_W'(pos_r) - EXP_W'(Q_FRAC);
   end

   // Sequencer state and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         num_r     <= 32'd0;
         pos_r     <= 5'd0;
         zero_r    <= 1'b0;
         out_valid <= 1'b0;
         out_mant  <= {MANT_W{1'b0}};
         out_exp   <= {EXP_W{1'b0}};
         out_zero  <= 1'b0;
      end else if (clear) begin
         state_r   <= ST_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  num_r   <= in_num;
                  state_r <= ST_DETECT;
               end
            end
            ST_DETECT: begin
               pos_r   <= lod(num_r);
               zero_r  <= (num_r == 32'd0);
               state_r <= ST_NORM;
            end
            ST_NORM: begin
               if (zero_r) begin
                  out_mant <= {MANT_W{1'b0}};
                  out_exp  <= {EXP_W{1'b0}};
               end else begin
                  out_mant <= mant_s;
                  out_exp  <= exp_s;
               end
               out_zero  <= zero_r;
               out_valid <= 1'b1;
               state_r   <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_r == ST_IDLE);
   assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_softmax_norm_ctrl.sv
// Scoreboard bench for softmax_norm_ctrl: directed vectors with hand-computed results,
// a negedge monitor pops expectations on every output handshake.
module tb_softmax_norm_ctrl;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_num;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_mant;
   logic [6:0]  out_exp;
   logic        out_zero;
   logic        busy;

   typedef struct {
      logic [15:0] m;
      logic [6:0]  e;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;

   softmax_norm_ctrl #(.Q_FRAC(16), .MANT_W(16), .EXP_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every output handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_output: got mant 0x%0h exp 0x%0h, expected no output", out_mant, out_exp);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_mant", 32'(out_mant), 32'(e.m));
            chk("out_exp",  32'(out_exp),  32'(e.e));
            chk("out_zero", 32'(out_zero), 32'(e.z));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, then holds in_valid over one accepting edge.
   task automatic send(input logic [31:0] num, input logic [15:0] m, input logic [6:0] e,
                       input logic z, input bit push, input bit keep_valid);
      int n;
      exp_t x;
      n = 0;
      in_num   = num;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      if (push) begin
         x.m = m; x.e = e; x.z = z;
         sb.push_back(x);
      end
      tick();
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   logic [31:0] s_num[8]  = '{32'h0000_0003, 32'h1234_5678, 32'h8000_0000, 32'h0000_FFFF,
                              32'h7FFF_FFFF, 32'h0000_0100, 32'h00AB_CDEF, 32'h0000_1234};
   logic [15:0] s_mant[8] = '{16'hC000, 16'h91A2, 16'h8000, 16'hFFFF,
                              16'hFFFF, 16'h8000, 16'hABCD, 16'h91A0};
   logic [6:0]  s_exp[8]  = '{7'h71, 7'h0C, 7'h0F, 7'h7F, 7'h0E, 7'h78, 7'h07, 7'h7C};

   initial begin
      logic [15:0] hm;
      logic [6:0]  he;
      int          last_acc;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_num = 32'd0; out_ready = 1'b1;
      #12;
      rst_n = 1'b1;
      tick();

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_out_mant",  32'(out_mant),  32'd0);
      chk("rst_out_exp",   32'(out_exp),   32'd0);
      chk("rst_out_zero",  32'(out_zero),  32'd0);

      // Test 1 with latency check.
      send(32'h0001_0000, 16'h8000, 7'h00, 1'b0, 1'b1, 1'b0);
      chk("lat_edge1", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge2", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge3", 32'(out_valid), 32'd1);
      drain();

      // Tests 2 and 3.
      send(32'h0001_8000, 16'hC000, 7'h00, 1'b0, 1'b1, 1'b0);
      send(32'h0000_0001, 16'h8000, 7'h70, 1'b0, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 16'hFFFF, 7'h0F, 1'b0, 1'b1, 1'b0);
      send(32'h0000_0000, 16'h0000, 7'h00, 1'b1, 1'b1, 1'b0);
      drain();

      // Test 4: back-pressure.
      out_ready = 1'b0;
      send(32'h0001_0000, 16'h8000, 7'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      chk("bp_valid_rise", 32'(out_valid), 32'd1);
      hm = out_mant;
      he = out_exp;
      in_num   = 32'h0000_5555;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_mant_hold", 32'(out_mant),  32'(hm));
         chk("bp_exp_hold",  32'(out_exp),   32'(he));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready",  32'(in_ready),  32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_drained",           32'(sb.size()), 32'd0);

      // Test 5: stream with in_valid held high; accepts must be 4 cycles apart.
      last_acc = 0;
      for (int i = 0; i < 8; i++) begin
         send(s_num[i], s_mant[i], s_exp[i], 1'b0, 1'b1, 1'b1);
         if (i > 0) chk("stream_accept_spacing", 32'(cyc - last_acc), 32'd4);
         last_acc = cyc;
      end
      in_valid = 1'b0;
      drain();

      // Test 6a: clear in DETECT drops the item and keeps the last result.
      send(32'h0003_0000, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b0);
      chk("clr_in_detect_busy", 32'(busy), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy",      32'(busy),      32'd0);
      chk("clr_in_ready",  32'(in_ready),  32'd1);
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      chk("clr_mant_kept", 32'(out_mant),  32'h91A0);
      chk("clr_exp_kept",  32'(out_exp),   32'h7C);

      // Clear with in_valid in IDLE accepts nothing.
      clear = 1'b1; in_valid = 1'b1; in_num = 32'h0000_0010;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_idle_no_accept", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) tick();

      // Test 6b: reset pulsed in NORM.
      send(32'h0004_0000, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
      chk("rst_mid_out_mant",  32'(out_mant),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("rst_mid_idle", 32'(busy), 32'd0);

      // Normal operation resumes after the aborted items.
      send(32'h0000_0003, 16'hC000, 7'h71, 1'b0, 1'b1, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
